dm_sba_axil_master: RTL and testbench
=====================================

Name: dm_sba_axil_master

Overview:
- Downstream stage of the debug module's system bus access (SBA) controller.
- Converts the controller's single-outstanding req/gnt/r_valid master interface into a 32-bit AXI4-Lite master.
- Maps bus response codes and a response timeout onto the controller's error inputs. This lets SBA traffic reach system memory over the SoC interconnect.

Parameters:
TimeoutCycles, 1024, cycles allowed from issue to response before a timeout error; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
dmactive_i  in  1  debug module active; gates new grants
master_req_i  in  1  access request
master_add_i  in  32  byte address
master_we_i  in  1  1 = write
master_wdata_i  in  32  write data, already lane-aligned
master_be_i  in  4  byte enables
master_gnt_o  out  1  request accepted
master_r_valid_o  out  1  one-cycle completion pulse (reads and writes)
master_r_err_o  out  1  bad-address error (DECERR)
master_r_other_err_o  out  1  other error (SLVERR or timeout)
master_r_rdata_o  out  32  read data
axi_awvalid_o / axi_awready_i  out/in  1  write address handshake
axi_awaddr_o  out  32  write address
axi_wvalid_o / axi_wready_i  out/in  1  write data handshake
axi_wdata_o  out  32  write data
axi_wstrb_o  out  4  write strobes
axi_bvalid_i / axi_bready_o  in/out  1  write response handshake
axi_bresp_i  in  2  write response
axi_arvalid_o / axi_arready_i  out/in  1  read address handshake
axi_araddr_o  out  32  read address
axi_rvalid_i / axi_rready_o  in/out  1  read data handshake
axi_rdata_i  in  32  read data
axi_rresp_i  in  2  read response

Behaviour:
- Reset: state Idle. All outputs are 0, including every valid/ready signal, the address/data/strobe registers, and the timeout counter.
- Reset mid-transaction abandons the transaction and produces no response.
- States: Idle, Write, WrResp, Read, RdResp, Drain.
- Idle:
  - master_gnt_o is combinational and equals master_req_i & dmactive_i. It is asserted in Idle only.
  - On grant, register address, wdata, and be; go to Write if master_we_i is set, else Read.
  - The counter clears on grant.
- Write:
  - axi_awvalid_o and axi_wvalid_o rise the cycle after the grant.
  - Each drops independently after its own handshake. Same-cycle handshakes are allowed.
  - Once both handshakes are done, go to WrResp with axi_bready_o = 1.
- Read: axi_arvalid_o is held until axi_arready_i, then go to RdResp with axi_rready_o = 1.
- WrResp/RdResp:
  - On the B or R handshake, register the response.
  - The cycle after the handshake, master_r_valid_o pulses for exactly one cycle. master_r_rdata_o carries axi_rdata_i (reads) or 0 (writes).
  - State returns to Idle in the same cycle as that pulse. The earliest new grant is the cycle after the pulse.
- Response mapping: OKAY and EXOKAY give no error. DECERR (2'b11) sets master_r_err_o. SLVERR (2'b10) sets master_r_other_err_o. The error outputs are valid only with master_r_valid_o and are 0 otherwise.
- Timeout (TimeoutCycles > 0):
  - The counter increments every cycle in Write, WrResp, Read, and RdResp.
  - When it reaches TimeoutCycles without completion, pulse master_r_valid_o with master_r_other_err_o = 1 and rdata = 0, then go to Drain.
  - A completion in the same cycle as the limit wins; no timeout fires.
- Drain:
  - Keep any still-pending awvalid, wvalid, or arvalid asserted until handshaken (AXI forbids withdrawal).
  - Hold bready/rready high and discard the late response without a second r_valid.
  - Return to Idle after the response is absorbed. No grants while in Drain.
- dmactive_i low: blocks new grants only. An in-flight transaction completes and reports normally.
- At most one outstanding transaction at any time. AXI valids never depend combinationally on readies.

Test Plan:
- Read 0x1000, arready=1 immediately, rvalid 2 cycles later with rdata=0xDEADBEEF, OKAY -> one gnt; araddr=0x1000; single r_valid with rdata=0xDEADBEEF, no errors.
- Write 0x2004, be=0x0C, wdata=0x00AB0000; wready 3 cycles before awready -> wstrb=0xC; each valid drops on its own handshake; bready only after both; one r_valid.
- Read returning DECERR, then write returning SLVERR -> first completion sets r_err=1 only; second sets r_other_err=1 only.
- TimeoutCycles=8, arready=1, rvalid withheld -> r_valid with other_err=1 exactly 8 cycles after ARVALID rises. Late R is accepted with no second pulse. Next req is granted only after the drain.
- req held with dmactive_i=0 -> no gnt and no AXI activity. Raise dmactive_i -> gnt the same cycle.
- Assert rst_ni low during RdResp, then release -> all outputs 0, state Idle, no r_valid pulse.

Source files
------------

// File: rtl/dm_sba_axil_master.sv
`default_nettype none
// ============================================================================
// Module   : dm_sba_axil_master
// Brief    : SBA req/gnt/r_valid master to 32-bit AXI4-Lite master bridge
//            with response-code mapping and response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module dm_sba_axil_master #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmactive_i,
    input  logic        master_req_i,
    input  logic [31:0] master_add_i,
    input  logic        master_we_i,
    input  logic [31:0] master_wdata_i,
    input  logic [3:0]  master_be_i,
    output logic        master_gnt_o,
    output logic        master_r_valid_o,
    output logic        master_r_err_o,
    output logic        master_r_other_err_o,
    output logic [31:0] master_r_rdata_o,
    output logic        axi_awvalid_o,
    input  logic        axi_awready_i,
    output logic [31:0] axi_awaddr_o,
    output logic        axi_wvalid_o,
    input  logic        axi_wready_i,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    input  logic        axi_bvalid_i,
    output logic        axi_bready_o,
    input  logic [1:0]  axi_bresp_i,
    output logic        axi_arvalid_o,
    input  logic        axi_arready_i,
    output logic [31:0] axi_araddr_o,
    input  logic        axi_rvalid_i,
    output logic        axi_rready_o,
    input  logic [31:0] axi_rdata_i,
    input  logic [1:0]  axi_rresp_i
);

    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLimit =
        CntW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_WRRESP = 3'd2;
    localparam logic [2:0] ST_READ   = 3'd3;
    localparam logic [2:0] ST_RDRESP = 3'd4;
    localparam logic [2:0] ST_DRAIN  = 3'd5;

    logic [2:0]      state;
    logic [CntW-1:0] cnt;
    logic [31:0]     addr;
    logic            is_write;

    logic grant, aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic active, completion, timeout;

    // The pulse cycle is already Idle, but a new grant must wait one more cycle.
    assign grant = (state == ST_IDLE) && !master_r_valid_o && master_req_i && dmactive_i;
    assign master_gnt_o = grant;

    assign aw_hs = axi_awvalid_o && axi_awready_i;
    assign w_hs  = axi_wvalid_o  && axi_wready_i;
    assign ar_hs = axi_arvalid_o && axi_arready_i;
    assign b_hs  = axi_bvalid_i  && axi_bready_o;
    assign r_hs  = axi_rvalid_i  && axi_rready_o;

    assign axi_awaddr_o = addr;
    assign axi_araddr_o = addr;

    assign active = (state == ST_WRITE) || (state == ST_WRRESP) ||
                    (state == ST_READ)  || (state == ST_RDRESP);
    assign completion = ((state == ST_WRRESP) && b_hs) || ((state == ST_RDRESP) && r_hs);
    // A response landing on the limit cycle takes precedence over the timeout.
    assign timeout = (TimeoutCycles != 0) && active && (cnt == CntLimit) && !completion;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state                <= ST_IDLE;
            cnt                  <= '0;
            addr                 <= '0;
            is_write             <= 1'b0;
            master_r_valid_o     <= 1'b0;
            master_r_err_o       <= 1'b0;
            master_r_other_err_o <= 1'b0;
            master_r_rdata_o     <= '0;
            axi_awvalid_o        <= 1'b0;
            axi_wvalid_o         <= 1'b0;
            axi_wdata_o          <= '0;
            axi_wstrb_o          <= '0;
            axi_bready_o         <= 1'b0;
            axi_arvalid_o        <= 1'b0;
            axi_rready_o         <= 1'b0;
        end else begin
            master_r_valid_o     <= 1'b0;
            master_r_err_o       <= 1'b0;
            master_r_other_err_o <= 1'b0;
            master_r_rdata_o     <= '0;

            // Valids retire on their own handshake in any state, including Drain.
            if (aw_hs) axi_awvalid_o <= 1'b0;
            if (w_hs)  axi_wvalid_o  <= 1'b0;
            if (ar_hs) axi_arvalid_o <= 1'b0;

            if (grant) begin
                cnt <= '0;
            end else if (active && (TimeoutCycles != 0)) begin
                cnt <= cnt + 1'b1;
            end

            if (timeout) begin
                master_r_valid_o     <= 1'b1;
                master_r_other_err_o <= 1'b1;
                state                <= ST_DRAIN;
                if (is_write) axi_bready_o <= 1'b1;
                else          axi_rready_o <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (grant) begin
                            addr        <= master_add_i;
                            axi_wdata_o <= master_wdata_i;
                            axi_wstrb_o <= master_be_i;
                            is_write    <= master_we_i;
                            if (master_we_i) begin
                                state         <= ST_WRITE;
                                axi_awvalid_o <= 1'b1;
                                axi_wvalid_o  <= 1'b1;
                            end else begin
                                state         <= ST_READ;
                                axi_arvalid_o <= 1'b1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if ((!axi_awvalid_o || aw_hs) && (!axi_wvalid_o || w_hs)) begin
                            state        <= ST_WRRESP;
                            axi_bready_o <= 1'b1;
                        end
                    end
                    ST_WRRESP: begin
                        if (b_hs) begin
                            axi_bready_o         <= 1'b0;
                            master_r_valid_o     <= 1'b1;
                            master_r_err_o       <= (axi_bresp_i == 2'b11);
                            master_r_other_err_o <= (axi_bresp_i == 2'b10);
                            state                <= ST_IDLE;
                        end
                    end
                    ST_READ: begin
                        if (ar_hs) begin
                            state        <= ST_RDRESP;
                            axi_rready_o <= 1'b1;
                        end
                    end
                    ST_RDRESP: begin
                        if (r_hs) begin
                            axi_rready_o         <= 1'b0;
                            master_r_valid_o     <= 1'b1;
                            master_r_rdata_o     <= axi_rdata_i;
                            master_r_err_o       <= (axi_rresp_i == 2'b11);
                            master_r_other_err_o <= (axi_rresp_i == 2'b10);
                            state                <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        // Late response is swallowed; the requester already saw the timeout.
                        if (b_hs || r_hs) begin
                            axi_bready_o <= 1'b0;
                            axi_rready_o <= 1'b0;
                            state        <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_sba_axil_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_sba_axil_master
// Brief    : Self-checking bench; latency/response model derived from the
//            bridge's cycle rules, with randomized AXI slave delays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_sba_axil_master;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dmactive = 1'b0;
    logic        req = 1'b0;
    logic [31:0] add = '0;
    logic        we_s = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  be_s = '0;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic        bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    wire         gnt, r_valid, r_err, r_other;
    wire  [31:0] r_rdata;
    wire         awvalid, wvalid, bready, arvalid, rready;
    wire  [31:0] awaddr, axi_wdata, araddr;
    wire  [3:0]  wstrb;

    wire [140:0] all_outs = {gnt, r_valid, r_err, r_other, r_rdata, awvalid, awaddr,
                             wvalid, axi_wdata, wstrb, bready, arvalid, araddr, rready};

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_sba_axil_master #(.TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
        .master_req_i(req), .master_add_i(add), .master_we_i(we_s),
        .master_wdata_i(wdata), .master_be_i(be_s),
        .master_gnt_o(gnt), .master_r_valid_o(r_valid), .master_r_err_o(r_err),
        .master_r_other_err_o(r_other), .master_r_rdata_o(r_rdata),
        .axi_awvalid_o(awvalid), .axi_awready_i(awready), .axi_awaddr_o(awaddr),
        .axi_wvalid_o(wvalid), .axi_wready_i(wready), .axi_wdata_o(axi_wdata),
        .axi_wstrb_o(wstrb), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
        .axi_bresp_i(bresp), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
        .axi_araddr_o(araddr), .axi_rvalid_i(rvalid), .axi_rready_o(rready),
        .axi_rdata_i(rdata), .axi_rresp_i(rresp)
    );

    task automatic idle_inputs();
        req = 1'b0; awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00;
    endtask

    // One transaction from its grant cycle up to the first cycle a new grant is legal.
    // Slave: each ready rises d_* cycles after the valids rise; the response arrives
    // d_b/d_r cycles after the requester's ready rises on its own schedule.
    task automatic run_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input int d_aw, input int d_w, input int d_b,
                           input int d_ar, input int d_r, input logic [1:0] resp,
                           input logic [31:0] rd, input bit drop_dma);
        int h, k, rv_rel, idle_rel, rdy_from;
        bit tmo;
        logic [5:0] exp_ctrl;
        logic [2:0] exp_resp;
        logic [31:0] exp_rdata;
        h        = we ? ((d_aw > d_w) ? d_aw : d_w) : d_ar;
        k        = h + 1 + (we ? d_b : d_r);
        tmo      = (k > int'(TO) - 1);
        rv_rel   = tmo ? int'(TO) : k + 1;
        idle_rel = tmo ? k + 1 : k + 2;
        rdy_from = (h + 1 < int'(TO)) ? h + 1 : int'(TO);
        exp_rdata = (!we && !tmo) ? rd : 32'h0;
        for (int rel = -1; rel < idle_rel; rel++) begin
            dmactive = (rel >= 0 && drop_dma) ? 1'b0 : 1'b1;
            req = 1'b1;
            if (rel == -1) begin
                add = a; we_s = we; wdata = wd; be_s = be;
            end else begin
                add = $urandom; we_s = 1'($urandom); wdata = $urandom; be_s = 4'($urandom);
            end
            awready = we && rel >= d_aw;
            wready  = we && rel >= d_w;
            arready = !we && rel >= d_ar;
            bvalid  = we && rel == k;
            rvalid  = !we && rel == k;
            bresp   = resp;
            rresp   = resp;
            rdata   = (rel == k) ? rd : $urandom;
            #1;
            exp_ctrl = {rel == -1,
                        we && rel >= 0 && rel <= d_aw,
                        we && rel >= 0 && rel <= d_w,
                        !we && rel >= 0 && rel <= d_ar,
                        we && rel >= rdy_from && rel <= k,
                        !we && rel >= rdy_from && rel <= k};
            exp_resp = {rel == rv_rel,
                        rel == rv_rel && !tmo && resp == 2'b11,
                        rel == rv_rel && (tmo || resp == 2'b10)};
            checks++;
            if ({gnt, awvalid, wvalid, arvalid, bready, rready} !== exp_ctrl) begin
                failures++;
                $display("FAIL ctrl rel=%0d gnt/aw/w/ar/b/r got=%b exp=%b", rel,
                         {gnt, awvalid, wvalid, arvalid, bready, rready}, exp_ctrl);
            end
            checks++;
            if ({r_valid, r_err, r_other} !== exp_resp) begin
                failures++;
                $display("FAIL resp rel=%0d valid/err/other got=%b exp=%b", rel,
                         {r_valid, r_err, r_other}, exp_resp);
            end
            if (rel == rv_rel) begin
                checks++;
                if (r_rdata !== exp_rdata) begin
                    failures++;
                    $display("FAIL rdata got=%h exp=%h", r_rdata, exp_rdata);
                end
            end
            if (rel == 0) begin
                checks++;
                if (we && {awaddr, axi_wdata, wstrb} !== {a, wd, be}) begin
                    failures++;
                    $display("FAIL aw/w payload got=%h/%h/%h exp=%h/%h/%h",
                             awaddr, axi_wdata, wstrb, a, wd, be);
                end else if (!we && araddr !== a) begin
                    failures++;
                    $display("FAIL araddr got=%h exp=%h", araddr, a);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        dmactive = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_outs !== '0) begin
            failures++;
            $display("FAIL reset_outs got=%h exp=0", all_outs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (all_outs !== '0) begin
            failures++;
            $display("FAIL post_reset_outs got=%h exp=0", all_outs);
        end
        @(negedge clk);
    endtask

    task automatic test_read_basic();
        run_txn(1'b0, 32'h1000, 32'h0, 4'h0, 0, 0, 0, 0, 1, 2'b00, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_write_basic();
        run_txn(1'b1, 32'h2004, 32'h00AB0000, 4'hC, 3, 0, 0, 0, 0, 2'b00, 32'h0, 1'b0);
    endtask

    task automatic test_error_mapping();
        run_txn(1'b0, 32'h4000, 32'h0, 4'hF, 0, 0, 0, 1, 0, 2'b11, 32'h12345678, 1'b0);
        run_txn(1'b1, 32'h4008, 32'h55AA55AA, 4'hF, 1, 1, 2, 0, 0, 2'b10, 32'h0, 1'b0);
        run_txn(1'b0, 32'h400C, 32'h0, 4'hF, 2, 0, 0, 0, 0, 2'b01, 32'hCAFEF00D, 1'b0);
    endtask

    task automatic test_timeout();
        // Read: arready at once, R withheld well past the limit.
        run_txn(1'b0, 32'h5000, 32'h0, 4'hF, 0, 0, 0, 0, 12, 2'b00, 32'hFEEDFACE, 1'b0);
        // Response exactly on the limit cycle completes normally; one later times out.
        run_txn(1'b0, 32'h5004, 32'h0, 4'hF, 0, 0, 0, 0, 6, 2'b00, 32'h0BADF00D, 1'b0);
        run_txn(1'b0, 32'h5008, 32'h0, 4'hF, 0, 0, 0, 0, 7, 2'b00, 32'h0BADF00D, 1'b0);
        // Write with AW still pending at timeout: awvalid must persist through Drain.
        run_txn(1'b1, 32'h500C, 32'h11112222, 4'h3, 10, 2, 0, 0, 0, 2'b00, 32'h0, 1'b0);
        run_txn(1'b1, 32'h5010, 32'h33334444, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 1'b0);
    endtask

    task automatic test_dmactive();
        idle_inputs();
        dmactive = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req = 1'b1; add = $urandom; we_s = 1'($urandom); wdata = $urandom;
            #1;
            checks++;
            if ({gnt, awvalid, wvalid, arvalid} !== 4'b0) begin
                failures++;
                $display("FAIL dmactive_block cyc=%0d gnt/aw/w/ar got=%b exp=0000", i,
                         {gnt, awvalid, wvalid, arvalid});
            end
            @(negedge clk);
        end
        run_txn(1'b0, 32'h6000, 32'h0, 4'hF, 1, 0, 0, 1, 1, 2'b00, 32'hA5A5A5A5, 1'b0);
        run_txn(1'b1, 32'h6004, 32'h9, 4'h1, 1, 2, 1, 0, 0, 2'b00, 32'h0, 1'b1);
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        dmactive = 1'b1; req = 1'b1; add = 32'h3000; we_s = 1'b0;
        #1;
        checks++;
        if (gnt !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_grant got=%b exp=1", gnt);
        end
        @(negedge clk);
        req = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (rready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_rdresp rready got=%b exp=1", rready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            failures++;
            $display("FAIL rst_mid_async got=%h exp=0", all_outs);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h77777777;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (all_outs !== '0) begin
                failures++;
                $display("FAIL rst_mid_quiet cyc=%0d got=%h exp=0", i, all_outs);
            end
            @(negedge clk);
        end
        rvalid = 1'b0;
        run_txn(1'b0, 32'h3004, 32'h0, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h13572468, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 6)), 2'($urandom), $urandom,
                    ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_error_mapping();
        test_timeout();
        test_dmactive();
        test_reset_mid();
        test_random();
        idle_inputs();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
